// File: rtl/div11_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : div11_pkg                                                    |
// | Desc   : Shared widths, FSM encoding and round-robin pick function    |
// |          for the BCD divisible-by-11 arbiter.                         |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package div11_pkg;

    localparam int         BCD_W     = 4;
    localparam int         WORD_W    = 16;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // First set request bit scanning last+1, last+2, ... modulo num_req (num_req <= 8).
    function automatic logic [2:0] rr_next(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         num_req);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (int'(last) + k) % num_req;
            if (k <= num_req && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div11_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : div11_core                                                   |
// | Desc   : Combinational 4-digit packed-BCD divisible-by-11 checker.    |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module div11_core
    import div11_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              div11,
    output logic              err
);

    localparam logic [5:0] c_POS11 = 6'd11;
    localparam logic [5:0] c_NEG11 = 6'd53;

    logic [BCD_W-1:0] w_dig [4];
    logic [3:0]       w_bad;
    logic [5:0]       w_s;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        assign w_dig[i] = word[BCD_W*i +: BCD_W];
        assign w_bad[i] = (w_dig[i] > DIGIT_MAX);
    end

    // Alternating digit sum in 6-bit two's complement; -11 wraps to 53.
    assign w_s = 6'(w_dig[0]) + 6'(w_dig[2]) - 6'(w_dig[1]) - 6'(w_dig[3]);

    assign err   = |w_bad;
    assign div11 = !err && ((w_s == 6'd0) || (w_s == c_POS11) || (w_s == c_NEG11));

endmodule
`default_nettype wire

// File: rtl/div11_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : div11_arbiter                                                |
// | Desc   : Round-robin time-share of one div11_core among requesters,   |
// |          with a tagged valid/ready result channel.                    |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module div11_arbiter
    import div11_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [WORD_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_div11,
    output logic                      rsp_err
);

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_last;
    logic [WORD_W-1:0]  r_word;
    logic [ID_W-1:0]    r_cap_id;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_div11;
    logic               r_err;

    logic [7:0]         w_req8;
    logic [2:0]         w_win;
    logic [NUM_REQ-1:0] w_gnt_next;
    logic               w_div11;
    logic               w_err;

    for (genvar i = 0; i < 8; i++) begin : g_req
        if (i < NUM_REQ) begin : g_used
            assign w_req8[i]     = req[i];
            assign w_gnt_next[i] = (w_win == 3'(i));
        end else begin : g_pad
            assign w_req8[i] = 1'b0;
        end
    end

    assign w_win = rr_next(w_req8, 3'(r_last), NUM_REQ);

    div11_core u_core (
        .word  (r_word),
        .div11 (w_div11),
        .err   (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= ID_W'(NUM_REQ - 1);
            r_word   <= '0;
            r_cap_id <= '0;
            r_gnt    <= '0;
            r_valid  <= 1'b0;
            r_rsp_id <= '0;
            r_div11  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_word   <= req_data[WORD_W*int'(w_win) +: WORD_W];
                        r_cap_id <= w_win[ID_W-1:0];
                        r_gnt    <= w_gnt_next;
                        r_state  <= EVAL;
                    end
                end
                EVAL: begin
                    r_gnt    <= '0;
                    r_rsp_id <= r_cap_id;
                    r_div11  <= w_div11;
                    r_err    <= w_err;
                    r_valid  <= 1'b1;
                    r_state  <= RESP;
                end
                RESP: begin
                    // Result fields return to zero so they read 0 outside RESP.
                    if (rsp_ready) begin
                        r_valid  <= 1'b0;
                        r_last   <= r_rsp_id;
                        r_rsp_id <= '0;
                        r_div11  <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_gnt    <= '0;
                    r_valid  <= 1'b0;
                    r_rsp_id <= '0;
                    r_div11  <= 1'b0;
                    r_err    <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != IDLE);
    assign rsp_valid = r_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_div11 = r_div11;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_div11_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_div11_arbiter                                             |
// | Desc   : Randomized self-checking bench for div11_arbiter.            |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module tb_div11_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req;
    logic [16*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]     gnt;
    logic                   busy;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_div11;
    logic                   rsp_err;

    int n_checks;
    int n_pass;
    int model_last;

    div11_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_div11 (rsp_div11),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic bit word_err(input logic [15:0] w);
        for (int i = 0; i < 4; i++)
            if (w[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: decimal value modulo 11.
    function automatic bit word_div(input logic [15:0] w);
        int v;
        if (word_err(w)) return 1'b0;
        v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(w[4*i +: 4]);
        return (v % 11) == 0;
    endfunction

    function automatic int rr_expect(input logic [NUM_REQ-1:0] rq, input int last);
        int idx;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (last + k) % NUM_REQ;
            if (rq[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       begin r = $urandom; return r[15:0]; end
            1:       return to_bcd(11 * int'($urandom_range(0, 909)));
            default: return to_bcd(int'($urandom_range(0, 9999)));
        endcase
    endfunction

    function automatic logic [16*NUM_REQ-1:0] rand_data();
        logic [16*NUM_REQ-1:0] d;
        for (int i = 0; i < NUM_REQ; i++) d[16*i +: 16] = rand_word();
        return d;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},   32'(gnt),       32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_id"},    32'(rsp_id),    32'd0);
        check({tag, "_div"},   32'(rsp_div11), 32'd0);
        check({tag, "_err"},   32'(rsp_err),   32'd0);
    endtask

    task automatic check_resp(input string tag, input int win, input bit e_div, input bit e_err);
        check({tag, "_gnt"},   32'(gnt),       32'd0);
        check({tag, "_busy"},  32'(busy),      32'd1);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"},    32'(rsp_id),    32'(win));
        check({tag, "_div"},   32'(rsp_div11), 32'(e_div));
        check({tag, "_err"},   32'(rsp_err),   32'(e_err));
    endtask

    // Entered with DUT idle and sampling at posedge+1.
    task automatic do_txn(input logic [NUM_REQ-1:0] rq, input logic [16*NUM_REQ-1:0] data,
                          input int stall);
        int          win;
        int          waited;
        logic [15:0] w;
        bit          e_err;
        bit          e_div;
        logic [31:0] rnd;
        win   = rr_expect(rq, model_last);
        w     = data[16*win +: 16];
        e_err = word_err(w);
        e_div = word_div(w);
        req      = rq;
        req_data = data;
        waited   = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (gnt == '0 && waited < 8);
        check("gnt_latency", 32'(waited), 32'd1);
        check("gnt_onehot", 32'(gnt), 32'd1 << win);
        check("eval_busy", 32'(busy), 32'd1);
        check("eval_valid", 32'(rsp_valid), 32'd0);
        check("eval_id", 32'(rsp_id), 32'd0);
        // Data and requests changing after grant must not affect anything.
        rnd      = $urandom;
        req      = rnd[NUM_REQ-1:0];
        req_data = rand_data();
        @(posedge clk); #1;
        check_resp("resp", win, e_div, e_err);
        for (int s = 0; s < stall; s++) begin
            rnd      = $urandom;
            req      = rnd[NUM_REQ-1:0];
            req_data = rand_data();
            @(posedge clk); #1;
            check_resp("stall", win, e_div, e_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_quiet("accept");
        model_last = win;
    endtask

    logic [15:0] dir_words [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [16*NUM_REQ-1:0] d;
        logic [31:0]           rnd;
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        dir_words = '{16'h1221, 16'h9999, 16'h1234, 16'h0000, 16'h0990,
                      16'h0121, 16'h0919, 16'h12A4, 16'hF000};
        #2;
        check_quiet("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        model_last = NUM_REQ - 1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("idle_noreq");

        foreach (dir_words[i]) begin
            d        = rand_data();
            d[15:0]  = dir_words[i];
            do_txn(4'b0001, d, 0);
        end

        do_txn(4'b0100, rand_data(), 10);

        // Asynchronous reset in the middle of EVAL.
        req      = 4'b0010;
        req_data = rand_data();
        @(posedge clk); #1;
        check("rst_pre_gnt", 32'(gnt), 32'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        check_quiet("rst_async");
        req = 4'b1000;
        @(posedge clk); #1;
        check_quiet("rst_held");
        rst_n      = 1'b1;
        model_last = NUM_REQ - 1;
        do_txn(4'b1000, rand_data(), 0);

        for (int i = 0; i < 5; i++) do_txn(4'b1111, rand_data(), 0);

        for (int i = 0; i < 40; i++) begin
            rnd = $urandom_range(1, (1 << NUM_REQ) - 1);
            do_txn(rnd[NUM_REQ-1:0], rand_data(), int'($urandom_range(0, 3)));
        end

        req = '0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
